alu_seq_ctrl: RTL and testbench
===============================

// Module: alu_seq_ctrl
// PURPOSE
//  Multi-cycle sequencer in front of the pure-combinational RV32I ALU (OP-IMM / OP only).
//  Fetches from instruction memory over a req/ack handshake and decodes fields onto the ALU inputs.
//  Registers the ALU result and writes it back to the register file.
//  Traps on illegal encodings and fetch timeouts. Sits between imem, regfile and ALU.
// PARAMETERS
//  RESET_PC       32'h0000_0000  PC loaded on reset
//  FETCH_TIMEOUT  255            max cycles in FETCH without imem_ack before trap (1..255)
// PORTS
//  clk          in   1   clock; all state updates on rising edge
//  reset        in   1   synchronous, active-high reset
//  halt         in   1   stop request; honoured only at instruction boundary
//  imem_req     out  1   fetch request; held until imem_ack
//  imem_addr    out  32  fetch address (= pc); stable while imem_req=1
//  imem_ack     in   1   fetch accepted; imem_rdata valid same cycle
//  imem_rdata   in   32  instruction word
//  rs1_addr     out  5   ir[19:15]
//  rs2_addr     out  5   ir[24:20]
//  alu_opcode   out  7   ir[6:0]
//  alu_funct3   out  3   ir[14:12]
//  alu_funct7   out  7   ir[31:25]
//  alu_imm      out  12  ir[31:20]
//  alu_shamt    out  5   ir[24:20]
//  alu_result   in   32  ALU output (combinational from the fields above plus rf read data)
//  rf_we        out  1   regfile write strobe, one cycle per retired insn with rd!=0
//  rf_waddr     out  5   ir[11:7]
//  rf_wdata     out  32  registered ALU result
//  busy         out  1   1 in every state except IDLE
//  illegal      out  1   sticky; 1 in TRAP
//  trap_cause   out  2   0 none, 1 illegal insn, 2 fetch timeout
//  pc           out  32  address of current/faulting instruction
//  retired      out  32  retired-instruction count, wraps 2^32-1 -> 0
// BEHAVIOUR
//  Reset values: state=IDLE, pc=RESET_PC, ir=0, retired=0, trap_cause=0. Outputs: imem_req=0, rf_we=0,
//   busy=0, illegal=0. Field outputs=0 (ir=0). reset has priority over all other inputs in the same cycle.
//  States: IDLE -> FETCH -> DECODE -> EXEC -> WB -> (FETCH | IDLE); TRAP absorbing until reset.
//  IDLE: leave to FETCH on the first cycle with halt=0.
//  FETCH: imem_req=1, imem_addr=pc. On imem_ack latch ir<=imem_rdata, go DECODE.
//   Ack in the first FETCH cycle is legal. tcnt increments each non-ack cycle.
//   When tcnt reaches FETCH_TIMEOUT -> TRAP, cause=2. tcnt clears on entering FETCH.
//  DECODE: rs1/rs2 driven; legality check. Illegal -> TRAP cause=1. Illegal means any of:
//   opcode not OP_IMM/OP; OP funct7 not 0x00/0x20; OP funct7=0x20 with funct3 not 000/101;
//   OP_IMM funct3=001 with imm[11:5]!=0; OP_IMM funct3=101 with imm[11:5] not 0x00/0x20.
//  EXEC: alu_result captured into rf_wdata register at end of cycle.
//  WB: rf_we=(rd!=0) for exactly this cycle. pc<=pc+4 (mod 2^32; 0xFFFF_FFFC wraps to 0, no trap).
//   retired<=retired+1. Next state IDLE if halt=1, else FETCH.
//  Minimum latency 4 cycles/insn (FETCH with same-cycle ack, DECODE, EXEC, WB); +1 per ack wait cycle.
//  TRAP: illegal=1, busy=1. pc, ir, retired frozen. imem_req=0, rf_we=0.
//  halt during FETCH/DECODE/EXEC: instruction still completes. Reset mid-operation: all state to
//   reset values next edge, imem_req drops, pending ack ignored, no write issued.
//  rd=x0: retires and counts, rf_we stays 0.
// STRUCTURE
//  Package alu_ctrl_pkg: state encoding (IDLE,FETCH,DECODE,EXEC,WB,TRAP), OP_IMM=7'b0010011,
//   OP_REG=7'b0110011, CAUSE_NONE/ILLEGAL/TIMEOUT, funct7 constants 0x00/0x20.
//  One sub-module: alu_insn_legal (combinational, in ir[31:0] -> out legal).
//  FSM, pc, ir, tcnt, retired and result registers in top.
// TESTING (bench includes a behavioural ALU + regfile model)
//  1 reset; imem returns ADDI x1,x0,5 (0x00500093) with same-cycle ack -> WB on cycle 4:
//    rf_we=1, waddr=1, wdata=5; then pc=4, retired=1.
//  2 ack delayed 3 cycles -> imem_req held, imem_addr stable, then WB 3 cycles later; result unchanged.
//  3 ADD x0,x1,x2 (0x00208033) -> rf_we never asserts; retired increments; pc+=4.
//  4 JAL word 0x0000006F -> TRAP after DECODE: illegal=1, trap_cause=1, pc unchanged, no rf_we.
//  5 SRAI with imm[11:5]=0x10 (0x41F0D093 edited) -> cause 1; no ack for 255 cycles -> cause 2.
//  6 halt=1 during EXEC -> WB completes, state IDLE, busy=0; reset during FETCH wait -> req=0, pc=RESET_PC.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// ==========================================================================
// alu_ctrl_pkg : shared encodings for the RV32I ALU sequencer
// Rev 1.0
// ==========================================================================
package alu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_ILLEGAL = 2'd1,
    CAUSE_TIMEOUT = 2'd2
  } cause_e;

  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_REG      = 7'b0110011;
  localparam logic [6:0] FUNCT7_BASE = 7'h00;
  localparam logic [6:0] FUNCT7_ALT  = 7'h20;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } insn_t;

endpackage
`default_nettype wire

// File: rtl/alu_insn_legal.sv
`default_nettype none
// ==========================================================================
// alu_insn_legal : flags instruction words the ALU path can execute
// Rev 1.0
// ==========================================================================
module alu_insn_legal
  import alu_ctrl_pkg::*;
(
  input  logic [31:0] ir,
  output logic        legal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_fields;

  assign opcode        = ir[6:0];
  assign funct3        = ir[14:12];
  assign funct7        = ir[31:25];
  assign unused_fields = ^{ir[24:15], ir[11:7]};

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_IMM: begin
        // Immediate shifts reuse imm[11:5] as a funct7-like field.
        case (funct3)
          3'b001:  legal = (funct7 == FUNCT7_BASE);
          3'b101:  legal = (funct7 == FUNCT7_BASE) || (funct7 == FUNCT7_ALT);
          default: legal = 1'b1;
        endcase
      end
      OP_REG: begin
        if (funct7 == FUNCT7_BASE) begin
          legal = 1'b1;
        end else if (funct7 == FUNCT7_ALT) begin
          legal = (funct3 == 3'b000) || (funct3 == 3'b101);
        end
      end
      default: legal = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ==========================================================================
// alu_seq_ctrl : fetch/decode/execute/writeback sequencer for an RV32I ALU
// Rev 1.0
// ==========================================================================
module alu_seq_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned FETCH_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        halt,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  output logic [6:0]  alu_opcode,
  output logic [2:0]  alu_funct3,
  output logic [6:0]  alu_funct7,
  output logic [11:0] alu_imm,
  output logic [4:0]  alu_shamt,
  input  logic [31:0] alu_result,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        busy,
  output logic        illegal,
  output logic [1:0]  trap_cause,
  output logic [31:0] pc,
  output logic [31:0] retired
);

  // Value tcnt holds on the last tolerated non-ack cycle.
  localparam logic [7:0] TCNT_LAST = 8'(FETCH_TIMEOUT - 1);

  state_e      state_q, state_d;
  cause_e      cause_q, cause_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] retired_q, retired_d;
  logic [31:0] result_q, result_d;
  logic [7:0]  tcnt_q, tcnt_d;
  logic        insn_legal;
  insn_t       fld;

  assign fld = insn_t'(ir_q);

  alu_insn_legal u_legal (
    .ir    (ir_q),
    .legal (insn_legal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cause_q   <= CAUSE_NONE;
      pc_q      <= RESET_PC;
      ir_q      <= 32'd0;
      retired_q <= 32'd0;
      result_q  <= 32'd0;
      tcnt_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      result_q  <= result_d;
      tcnt_q    <= tcnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    result_d  = result_q;
    tcnt_d    = tcnt_q;
    imem_req  = 1'b0;
    rf_we     = 1'b0;
    busy      = 1'b1;
    illegal   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (!halt) begin
          state_d = ST_FETCH;
          tcnt_d  = 8'd0;
        end
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = ST_DECODE;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
          if (tcnt_q == TCNT_LAST) begin
            state_d = ST_TRAP;
            cause_d = CAUSE_TIMEOUT;
          end
        end
      end
      ST_DECODE: begin
        if (insn_legal) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      ST_EXEC: begin
        result_d = alu_result;
        state_d  = ST_WB;
      end
      ST_WB: begin
        rf_we     = (fld.rd != 5'd0);
        pc_d      = pc_q + 32'd4;
        retired_d = retired_q + 32'd1;
        tcnt_d    = 8'd0;
        state_d   = halt ? ST_IDLE : ST_FETCH;
      end
      ST_TRAP: begin
        illegal = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign imem_addr  = pc_q;
  assign rs1_addr   = fld.rs1;
  assign rs2_addr   = fld.rs2;
  assign alu_opcode = fld.opcode;
  assign alu_funct3 = fld.funct3;
  assign alu_funct7 = fld.funct7;
  assign alu_imm    = ir_q[31:20];
  assign alu_shamt  = ir_q[24:20];
  assign rf_waddr   = fld.rd;
  assign rf_wdata   = result_q;
  assign trap_cause = cause_q;
  assign pc         = pc_q;
  assign retired    = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
`default_nettype none
// ==========================================================================
// tb_alu_seq_ctrl : directed + random bench with ALU/regfile models
// Rev 1.0
// ==========================================================================
module tb_alu_seq_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        reset, halt, imem_req, imem_ack, rf_we, busy, illegal;
  logic [31:0] imem_addr, imem_rdata, alu_result, rf_wdata, pc, retired;
  logic [4:0]  rs1_addr, rs2_addr, rf_waddr, alu_shamt;
  logic [6:0]  alu_opcode, alu_funct7;
  logic [2:0]  alu_funct3;
  logic [11:0] alu_imm;
  logic [1:0]  trap_cause;

  int          n_checks, n_fail;
  logic [31:0] env_rf [32];
  logic [31:0] ref_rf [32];
  logic [31:0] exp_pc, exp_ret;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  alu_seq_ctrl #(.RESET_PC(RESET_PC), .FETCH_TIMEOUT(255)) dut (
    .clk(clk), .reset(reset), .halt(halt),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .alu_opcode(alu_opcode), .alu_funct3(alu_funct3),
    .alu_funct7(alu_funct7), .alu_imm(alu_imm), .alu_shamt(alu_shamt), .alu_result(alu_result),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy(busy), .illegal(illegal),
    .trap_cause(trap_cause), .pc(pc), .retired(retired)
  );

  function automatic logic [31:0] seed_val(input int i);
    if (i == 0) return 32'd0;
    return (32'(i) * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  // RV32I OP-IMM / OP arithmetic from the ISA definition.
  function automatic logic [31:0] alu_calc(input logic [6:0] op, input logic [2:0] f3,
                                           input logic [6:0] f7, input logic [11:0] imm,
                                           input logic [4:0] sh, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] x;
    int unsigned s;
    bit          alt, is_imm;
    is_imm = (op == 7'b0010011);
    x      = is_imm ? {{20{imm[11]}}, imm} : b;
    s      = is_imm ? sh : b[4:0];
    alt    = f7[5];
    case (f3)
      3'd0:    return (!is_imm && alt) ? a - x : a + x;
      3'd1:    return a << s;
      3'd2:    return ($signed(a) < $signed(x)) ? 32'd1 : 32'd0;
      3'd3:    return (a < x) ? 32'd1 : 32'd0;
      3'd4:    return a ^ x;
      3'd5:    return alt ? 32'($signed(a) >>> s) : (a >> s);
      3'd6:    return a | x;
      default: return a & x;
    endcase
  endfunction

  // Environment: register file and combinational ALU fed by the DUT's fields.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) env_rf[i] <= seed_val(i);
    end else if (rf_we && rf_waddr != 5'd0) begin
      env_rf[rf_waddr] <= rf_wdata;
    end
  end

  always_comb alu_result = alu_calc(alu_opcode, alu_funct3, alu_funct7, alu_imm, alu_shamt,
                                    env_rf[rs1_addr], env_rf[rs2_addr]);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rand_legal();
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm;
    logic [6:0]  f7;
    f3  = 3'($urandom_range(0, 7));
    rd  = 5'($urandom);
    rs1 = 5'($urandom);
    rs2 = 5'($urandom);
    if ($urandom_range(0, 1) == 1) begin
      imm = 12'($urandom);
      if (f3 == 3'd1) imm[11:5] = 7'h00;
      else if (f3 == 3'd5) imm[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      return {imm, rs1, f3, rd, 7'b0010011};
    end
    f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  task automatic do_reset();
    reset    = 1'b1;
    halt     = 1'b0;
    imem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst.busy", busy, 0);
    chk("rst.req", imem_req, 0);
    chk("rst.we", rf_we, 0);
    chk("rst.illegal", illegal, 0);
    chk("rst.cause", trap_cause, 0);
    chk("rst.pc", pc, RESET_PC);
    chk("rst.retired", retired, 0);
    chk("rst.fields", {alu_funct7, rs2_addr, rs1_addr, alu_funct3, rf_waddr, alu_opcode}, 0);
    reset   = 1'b0;
    exp_pc  = RESET_PC;
    exp_ret = 32'd0;
    for (int i = 0; i < 32; i++) ref_rf[i] = seed_val(i);
  endtask

  task automatic wait_req(input string tag);
    int w;
    w = 0;
    while (!imem_req && w < 8) begin
      @(negedge clk);
      w++;
    end
    chk({tag, ".req"}, imem_req, 1);
  endtask

  task automatic run_insn(input string tag, input logic [31:0] insn, input int ack_delay,
                          input bit halt_in_exec, input bit expect_illegal);
    logic [31:0] pc0, expv;
    logic [4:0]  rd;
    pc0  = exp_pc;
    rd   = insn[11:7];
    expv = alu_calc(insn[6:0], insn[14:12], insn[31:25], insn[31:20], insn[24:20],
                    ref_rf[insn[19:15]], ref_rf[insn[24:20]]);
    wait_req(tag);
    chk({tag, ".addr"}, imem_addr, pc0);
    for (int d = 0; d < ack_delay; d++) begin
      @(negedge clk);
      chk({tag, ".hold_req"}, imem_req, 1);
      chk({tag, ".hold_addr"}, imem_addr, pc0);
    end
    imem_ack   = 1'b1;
    imem_rdata = insn;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    chk({tag, ".dec_fields"}, {alu_funct7, rs2_addr, rs1_addr, alu_funct3, rf_waddr, alu_opcode}, insn);
    chk({tag, ".dec_imm"}, {alu_imm, alu_shamt}, {insn[31:20], insn[24:20]});
    chk({tag, ".dec_req_we"}, {imem_req, rf_we, busy}, 3'b001);
    @(negedge clk);
    if (expect_illegal) begin
      chk({tag, ".trap"}, {illegal, trap_cause, busy, imem_req, rf_we}, 6'b1_01_1_0_0);
      chk({tag, ".trap_pc"}, pc, pc0);
      chk({tag, ".trap_ret"}, retired, exp_ret);
      return;
    end
    chk({tag, ".exec"}, {illegal, rf_we, imem_req}, 3'b000);
    if (halt_in_exec) halt = 1'b1;
    @(negedge clk);
    chk({tag, ".wb_we"}, rf_we, (rd != 5'd0));
    chk({tag, ".wb_waddr"}, rf_waddr, rd);
    chk({tag, ".wb_wdata"}, rf_wdata, expv);
    if (rd != 5'd0) ref_rf[rd] = expv;
    exp_pc  = exp_pc + 32'd4;
    exp_ret = exp_ret + 32'd1;
    @(negedge clk);
    chk({tag, ".pc"}, pc, exp_pc);
    chk({tag, ".retired"}, retired, exp_ret);
    chk({tag, ".post_we"}, rf_we, 0);
    if (halt_in_exec) chk({tag, ".halt_idle"}, {busy, imem_req}, 2'b00);
  endtask

  initial begin
    int cnt;
    n_checks   = 0;
    n_fail     = 0;
    reset      = 1'b1;
    halt       = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;

    // Basic retire paths: same-cycle ack, delayed ack, rd = x0.
    do_reset();
    run_insn("t1_addi", 32'h0050_0093, 0, 1'b0, 1'b0);
    chk("t1.pc_is_4", pc, 32'd4);
    run_insn("t2_delay", 32'h0050_0093, 3, 1'b0, 1'b0);
    run_insn("t3_x0", 32'h0020_8033, 1, 1'b0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      run_insn("rnd", rand_legal(), int'($urandom_range(0, 3)), 1'b0, 1'b0);
    end

    // Illegal JAL: trap must hold everything even when imem keeps acking.
    run_insn("t4_jal", 32'h0000_006F, 0, 1'b0, 1'b1);
    imem_ack = 1'b1;
    repeat (3) @(negedge clk);
    imem_ack = 1'b0;
    chk("t4.frozen", {illegal, trap_cause, busy, imem_req, rf_we}, 6'b1_01_1_0_0);
    chk("t4.frozen_pc", pc, exp_pc);
    chk("t4.frozen_ret", retired, exp_ret);

    do_reset();
    run_insn("t5_srai_bad", 32'h21F0_D093, 0, 1'b0, 1'b1);

    // Fetch timeout: 255 non-ack FETCH cycles, trap on the next.
    do_reset();
    wait_req("t5_to");
    cnt = 1;
    for (int k = 0; k < 254; k++) begin
      @(negedge clk);
      if (imem_req) cnt++;
    end
    chk("t5.to_hold_cycles", cnt, 255);
    chk("t5.to_not_yet", illegal, 0);
    @(negedge clk);
    chk("t5.to_trap", {illegal, trap_cause, imem_req, busy}, 5'b1_10_0_1);
    chk("t5.to_pc", pc, RESET_PC);

    // Halt during EXEC, then reset during a FETCH wait with an ack pending.
    do_reset();
    run_insn("t6_halt", 32'h0050_0093, 0, 1'b1, 1'b0);
    @(negedge clk);
    chk("t6.still_idle", {busy, imem_req}, 2'b00);
    halt = 1'b0;
    run_insn("t6_resume", rand_legal(), 2, 1'b0, 1'b0);
    wait_req("t6_rst");
    repeat (2) @(negedge clk);
    reset      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'h00A0_0293;
    @(negedge clk);
    chk("t6.rst_req", imem_req, 0);
    chk("t6.rst_pc", pc, RESET_PC);
    chk("t6.rst_ret", retired, 0);
    chk("t6.rst_we_busy", {rf_we, busy}, 2'b00);
    imem_ack = 1'b0;
    reset    = 1'b0;
    exp_pc   = RESET_PC;
    exp_ret  = 32'd0;
    for (int i = 0; i < 32; i++) ref_rf[i] = seed_val(i);
    run_insn("t6_after", 32'h00A0_0293, 1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
